// File: rtl/reg_write_arbiter_if.sv
// ============================================================================
// Module      : reg_write_arbiter_if
// Description : Request/grant and register-bank write bus of reg_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif

interface reg_write_arbiter_if #(
    parameter int n  = `WORD_LENGTH,
    parameter int AW = 3
);
    localparam int REGS = 1 << AW;

    logic [3:0]      req;
    logic [3:0]      lock;
    logic [4*AW-1:0] addr;
    logic [4*n-1:0]  data;
    logic [3:0]      gnt;
    logic [REGS-1:0] wr_en;
    logic [n-1:0]    wr_data;
    logic            locked;

    // Requesters plus the bank side, as seen from outside the arbiter.
    modport master (
        output req, lock, addr, data,
        input  gnt, wr_en, wr_data, locked
    );

    modport slave (
        input  req, lock, addr, data,
        output gnt, wr_en, wr_data, locked
    );
endinterface

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter for the register-bank write port with
//               one-hot enable decode. Optional burst lock: REG_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif

module reg_write_arbiter #(
    parameter int n  = `WORD_LENGTH,
    parameter int AW = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    reg_write_arbiter_if.slave bus
);
    localparam int REGS = 1 << AW;

    logic [1:0]      ptr_q;
    logic [1:0]      ptr_d;
    logic [REGS-1:0] wr_en_q;
    logic [n-1:0]    wr_data_q;

    logic [3:0]      gnt_c;
    logic [1:0]      win;
    logic            any_gnt;
    logic [AW-1:0]   win_addr;
    logic [n-1:0]    win_data;
    logic [REGS-1:0] en_dec;

`ifdef REG_ARB_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] owner_q;
    logic [1:0] owner_d;
    logic       locked_q;

    always_comb begin
        gnt_c   = '0;
        win     = ptr_q;
        any_gnt = 1'b0;
        ptr_d   = ptr_q;
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                for (int k = 0; k < 4; k++) begin
                    if (!any_gnt && bus.req[ptr_q + 2'(k)]) begin
                        any_gnt = 1'b1;
                        win     = ptr_q + 2'(k);
                    end
                end
                if (any_gnt) begin
                    gnt_c[win] = 1'b1;
                    ptr_d      = win + 2'd1;
                    if (bus.lock[win]) begin
                        state_d = ST_LOCKED;
                        owner_d = win;
                    end
                end
            end
            ST_LOCKED: begin
                // Only the owner is visible; a dropped req releases without a beat.
                win = owner_q;
                if (bus.req[owner_q]) begin
                    any_gnt        = 1'b1;
                    gnt_c[owner_q] = 1'b1;
                end
                if (!bus.req[owner_q] || !bus.lock[owner_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 2'd0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign bus.locked = locked_q;
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;

    always_comb begin
        gnt_c   = '0;
        win     = ptr_q;
        any_gnt = 1'b0;
        ptr_d   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!any_gnt && bus.req[ptr_q + 2'(k)]) begin
                any_gnt = 1'b1;
                win     = ptr_q + 2'(k);
            end
        end
        if (any_gnt) begin
            gnt_c[win] = 1'b1;
            ptr_d      = win + 2'd1;
        end
    end

    assign bus.locked = 1'b0;
`endif

    // Register 0 is hard-wired zero, so its enable is never raised.
    always_comb begin
        win_addr = bus.addr[win*AW +: AW];
        win_data = bus.data[win*n +: n];
        en_dec   = '0;
        if (win_addr != '0) begin
            en_dec[win_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= 2'd0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wr_en_q <= any_gnt ? en_dec : '0;
            if (any_gnt) begin
                wr_data_q <= win_data;
            end
        end
    end

    assign bus.gnt     = rst ? 4'b0000 : gnt_c;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;

endmodule

`default_nettype wire

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the single write port of the register bank (a row of enable/reset flip-flops, one per register) between four requesters: fetch, ALU writeback, load unit and debug port. It grants one requester per cycle, decodes the winning address into a one-hot enable vector, and registers the enable and data toward the bank. Optional lock support lets a requester hold the port for multi-cycle bursts.

## Interface
- `n`, default `WORD_LENGTH`: data width in bits.
- `AW`, default 3: register address width; bank size `REGS = 1 << AW`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state immediately.
- `req`  in  4  per-requester write request; bit i belongs to requester i.
- `lock`  in  4  per-requester burst lock; only meaningful with `req[i]` high.
- `addr`  in  4*AW  flattened target addresses; requester i uses bits `[i*AW +: AW]`.
- `data`  in  4*n  flattened write data; requester i uses bits `[i*n +: n]`.
- `gnt`  out  4  one-hot combinational grant; zero when no request or while `rst` is high.
- `wr_en`  out  REGS  registered one-hot enable, bit k drives the enable of register k.
- `wr_data`  out  n  registered write data, shared by all registers.
- `locked`  out  1  registered; high while state is LOCKED.

## Operation
- State: round-robin pointer `ptr` (2 bits), FSM `{IDLE, LOCKED}`, `owner` (2 bits).
- IDLE: search `req` starting at `ptr`, then ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins, and `gnt` is one-hot on the winner. With no request, `gnt` = 0 and `ptr` holds.
- After a grant to i in IDLE: `ptr` <= (i+1) mod 4. If `lock[i]` is high, the FSM goes to LOCKED and `owner` <= i.
- LOCKED: only `owner` can be granted, and requests from other requesters are ignored (their `gnt` stays 0).
  - If `req[owner]` is high, `gnt[owner]` = 1. If `lock[owner]` is also low, this is the last beat and the FSM returns to IDLE.
  - If `req[owner]` is low, the lock is released immediately: FSM to IDLE, no grant that cycle.
  - On any exit from LOCKED, `ptr` <= (owner+1) mod 4.
- Transfer rule: a write transfers on the rising edge that ends a cycle in which `gnt[i]` is high.
  - The requester drops `req`, or presents its next beat, in the following cycle.
  - A requester whose `req` stays high in IDLE simply competes again.
- Write generation:
  - On a transfer, `wr_en` <= one-hot(addr_i) and `wr_data` <= data_i.
  - On a transfer to address 0, `wr_en` <= all-zero: register 0 is read-only zero. The requester is still granted and `wr_data` still updates.
  - With no transfer, `wr_en` <= 0 and `wr_data` holds its value.
- `locked` <= (next FSM state == LOCKED).

## Timing
- Reset values: `ptr` = 0, FSM = IDLE, `owner` = 0, `wr_en` = 0, `wr_data` = 0, `locked` = 0. `gnt` is forced to 0 while `rst` is high.
- Latency from request to grant: same cycle (`gnt` is combinational from `req`/`lock` and state).
- Grant to bank update: `wr_en`/`wr_data` are valid one cycle after the grant, and the bank captures at the end of that cycle. Total latency is 2 edges from the first `req` sample.
- Throughput: one write per cycle, sustained.
- Reset asserted mid-burst: FSM returns to IDLE and any pending `wr_en` is cleared at once. The in-flight write is lost, not replayed.
- Multiple simultaneous requests are resolved purely by `ptr` order, so no requester waits more than 3 grants in IDLE.

## Configuration
- `REG_ARB_LOCK_EN` defined: `lock` input, LOCKED state, `owner` and the `locked` output all behave as described above.
- `REG_ARB_LOCK_EN` undefined:
  - `lock` is ignored and the FSM is permanently IDLE.
  - `locked` is tied to 0 and `owner` logic is removed.
  - Arbitration is pure per-cycle round-robin.

## Test plan
- Reset then idle: `rst` pulse, `req`=0 for 5 cycles -> `gnt`=0, `wr_en`=0, `wr_data`=0, `locked`=0 throughout.
- Single write: `req`=0001 with addr0=3, data0=0xA5 for 1 cycle -> `gnt`=0001 that cycle; next cycle `wr_en`=0x08, `wr_data`=0xA5; `ptr`=1.
- Round-robin fairness: `req`=1111 held for 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3, with `wr_en` following each requester's address one cycle later.
- Address 0 drop: requester 2 writes addr=0, data=0x55 -> `gnt`=0100; next cycle `wr_en`=0 and `wr_data`=0x55.
- Lock burst (macro defined): requester 1 asserts req+lock for 3 beats, then req without lock, while `req`=1111 throughout -> `gnt`=0010 for 4 consecutive cycles and `locked`=1 for the first 3 registered cycles. The next grant goes to requester 2.
- Reset mid-burst: assert `rst` during LOCKED while a write is pending -> `locked`=0 and `wr_en`=0 immediately. After release, `req`=1000 grants requester 3 in the first cycle.
